// File: rtl/nanci_pkg.sv
// Shared Nanci definitions: result-drain state encoding and counter-width helper.
`default_nettype none

package nanci_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } drain_state_t;

   // Width needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pe_result_drain_if.sv
// Result stream from pe_result_drain to its consumer (valid/ready).
`default_nettype none

interface pe_result_drain_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  i_ready;

   modport master (output o_data, output o_valid, input i_ready);
   modport slave  (input o_data, input o_valid, output i_ready);
endinterface

`default_nettype wire

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous FIFO with a registered head word; push+pop allowed when full.
`default_nettype none

module drain_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  push,
   input  wire logic [DATA_WIDTH-1:0] din,
   input  wire logic                  pop,
   output logic      [DATA_WIDTH-1:0] dout,
   output logic                       full,
   output logic                       empty,
   output logic      [ADDR_WIDTH:0]   count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr_next;
   logic [ADDR_WIDTH:0]   count_after_pop;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  do_push;
   logic                  do_pop;

   assign full            = (count == DEPTH_CNT);
   assign empty           = (count == '0);
   assign do_pop          = pop && !empty;
   assign do_push         = push && (!full || do_pop);
   assign rd_ptr_next     = rd_ptr + ADDR_WIDTH'(do_pop);
   assign count_after_pop = count - (ADDR_WIDTH + 1)'(do_pop);
   assign count_next      = count_after_pop + (ADDR_WIDTH + 1)'(do_push);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // The head register is loaded with the incoming word when it lands in an
   // otherwise empty queue, since that slot is not yet readable from mem.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         if (count_next != '0) begin
            dout <= (count_after_pop == '0) ? din : mem[rd_ptr_next];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pe_result_drain.sv
// pe_result_drain: captures N PE result words at a fixed window and drains them over valid/ready.
// Optional feature macro: PE_DRAIN_SORTED_CHECK_EN (adds o_unsorted order monitor).
`default_nettype none

module pe_result_drain
   import nanci_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int N               = 4,
   parameter int WAIT_CYCLES     = 11,
   parameter int FIFO_ADDR_WIDTH = 3
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  i_start,
   input  wire logic [DATA_WIDTH-1:0] i_PE,
   pe_result_drain_if.master          out_if,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_overflow
`ifdef PE_DRAIN_SORTED_CHECK_EN
   ,
   output logic                       o_unsorted
`endif
);

   localparam int WW = cnt_width(WAIT_CYCLES);
   localparam int CW = cnt_width(N);
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] CAP_LAST  = CW'(N - 1);

   drain_state_t              state;
   logic [WW-1:0]             wait_cnt;
   logic [CW-1:0]             cap_cnt;
   logic [DATA_WIDTH-1:0]     fifo_dout;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [FIFO_ADDR_WIDTH:0]  fifo_count;
   logic                      capturing;
   logic                      pop;
   logic                      drop;
   logic                      start_ok;

   assign out_if.o_data  = fifo_dout;
   assign out_if.o_valid = !fifo_empty;

   assign capturing = (state == ST_CAPTURE);
   assign pop       = out_if.o_valid && out_if.i_ready;
   assign drop      = capturing && fifo_full && !pop;
   // A new run may only begin once the previous run's words are all drained.
   assign start_ok  = i_start && ((state == ST_IDLE) ||
                                  ((state == ST_DONE) && (fifo_count == '0)));

   drain_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (capturing),
      .din   (i_PE),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         cap_cnt    <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_overflow <= 1'b0;
      end else if (start_ok) begin
         state      <= (WAIT_CYCLES == 0) ? ST_CAPTURE : ST_WAIT;
         wait_cnt   <= '0;
         cap_cnt    <= '0;
         o_busy     <= 1'b1;
         o_done     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state   <= ST_CAPTURE;
                  cap_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            ST_CAPTURE: begin
               cap_cnt <= cap_cnt + CW'(1);
               if (drop) begin
                  o_overflow <= 1'b1;
               end
               if (cap_cnt == CAP_LAST) begin
                  state  <= ST_DONE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PE_DRAIN_SORTED_CHECK_EN
   logic [DATA_WIDTH-1:0] prev_word;
   logic                  have_prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_word  <= '0;
         have_prev  <= 1'b0;
         o_unsorted <= 1'b0;
      end else if (start_ok) begin
         have_prev  <= 1'b0;
         o_unsorted <= 1'b0;
      end else if (pop) begin
         if (have_prev && (fifo_dout < prev_word)) begin
            o_unsorted <= 1'b1;
         end
         prev_word <= fifo_dout;
         have_prev <= 1'b1;
      end
   end
`else
   // Order monitor not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_result_drain.sv
// Scoreboard bench for pe_result_drain: directed scenarios plus randomized traffic against a queue model.
`default_nettype none

module tb_pe_result_drain;

   localparam int DW    = 8;
   localparam int NW    = 4;
   localparam int WC    = 11;
   localparam int FAW   = 1;
   localparam int DEPTH = 1 << FAW;

   logic          clk    = 1'b0;
   logic          rst    = 1'b0;
   logic          start  = 1'b0;
   logic [DW-1:0] pe_in  = '0;
   logic          busy;
   logic          done;
   logic          ovf;
`ifdef PE_DRAIN_SORTED_CHECK_EN
   logic          uns;
`endif

   pe_result_drain_if #(.DATA_WIDTH(DW)) out_if ();

   pe_result_drain #(
      .DATA_WIDTH      (DW),
      .N               (NW),
      .WAIT_CYCLES     (WC),
      .FIFO_ADDR_WIDTH (FAW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (start),
      .i_PE       (pe_in),
      .out_if     (out_if),
      .o_busy     (busy),
      .o_done     (done),
      .o_overflow (ovf)
`ifdef PE_DRAIN_SORTED_CHECK_EN
      ,
      .o_unsorted (uns)
`endif
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: run start edge, words held in the FIFO, sticky flags.
   int            cyc       = 0;
   int            t_start   = 0;
   bit            run       = 1'b0;
   bit [DW-1:0]   mq[$];
   bit [DW-1:0]   exp_q[$];
   bit            m_ovf     = 1'b0;
   bit            m_uns     = 1'b0;
   bit            have_prev = 1'b0;
   bit [DW-1:0]   prev      = '0;
   bit            after_rst = 1'b0;
   logic [DW-1:0] stream [NW];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s after edge %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Checks outputs of the cycle just entered, then advances the model to the next edge.
   always @(negedge clk) begin
      int      ne;
      int      last;
      int      sz;
      bit      mpop;
      bit      capt;
      bit [DW-1:0] w;
      last = t_start + WC + NW;
      chk("valid", 32'(out_if.o_valid), 32'(mq.size() > 0));
      chk("busy",  32'(busy), 32'(run && cyc >= t_start && cyc < last));
      chk("done",  32'(done), 32'(run && cyc >= last));
      chk("overflow", 32'(ovf), 32'(m_ovf));
`ifdef PE_DRAIN_SORTED_CHECK_EN
      chk("unsorted", 32'(uns), 32'(m_uns));
`endif
      if (after_rst) chk("data_after_reset", 32'(out_if.o_data), 32'h0);
      if (rst && out_if.o_valid && out_if.i_ready) begin
         if (exp_q.size() == 0) chk("unexpected_word", 32'(out_if.o_data), 32'hFFFF_FFFF);
         else chk("data", 32'(out_if.o_data), 32'(exp_q.pop_front()));
      end

      ne = cyc + 1;
      after_rst = !rst;
      if (!rst) begin
         run = 0; mq.delete(); exp_q.delete();
         m_ovf = 0; m_uns = 0; have_prev = 0;
      end else begin
         sz   = mq.size();
         mpop = (sz > 0) && out_if.i_ready;
         capt = run && ne > t_start + WC && ne <= last;
         if (mpop) begin
            w = mq.pop_front();
            if (have_prev && w < prev) m_uns = 1;
            prev = w;
            have_prev = 1;
         end
         if (capt) begin
            if (sz < DEPTH || mpop) begin
               mq.push_back(pe_in);
               exp_q.push_back(pe_in);
            end else begin
               m_ovf = 1;
            end
         end
         if (start && (!run || (ne > last && sz == 0))) begin
            run = 1; t_start = ne; m_ovf = 0; m_uns = 0; have_prev = 0;
         end
      end
      cyc = ne;
   end

   task automatic step(input logic st, input logic [DW-1:0] pe, input logic rdy, input logic rn);
      start = st; pe_in = pe; out_if.i_ready = rdy; rst = rn;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy_of(input int mode);
      return (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode);
   endfunction

   task automatic run_capture(input int mode);
      step(1'b1, DW'($urandom), rdy_of(mode), 1'b1);
      repeat (WC) step(1'b0, DW'($urandom), rdy_of(mode), 1'b1);
      for (int i = 0; i < NW; i++) step(1'b0, stream[i], rdy_of(mode), 1'b1);
   endtask

   task automatic drain(input int n, input int mode);
      repeat (n) step(1'b0, DW'($urandom), rdy_of(mode), 1'b1);
   endtask

   initial begin
      out_if.i_ready = 1'b0;
      repeat (3) step(1'b0, DW'($urandom), 1'b0, 1'b0);
      drain(2, 1);

      // In-order capture with consumer always ready
      for (int i = 0; i < NW; i++) stream[i] = DW'(8'h10 + i);
      run_capture(1);
      drain(8, 1);

      // Consumer stalled: FIFO fills, later words dropped
      for (int i = 0; i < NW; i++) stream[i] = DW'($urandom);
      run_capture(0);
      drain(4, 0);
      drain(6, 1);

      // Reset during the second capture, then a clean run
      for (int i = 0; i < NW; i++) stream[i] = DW'($urandom);
      step(1'b1, DW'($urandom), 1'b1, 1'b1);
      repeat (WC) step(1'b0, DW'($urandom), 1'b1, 1'b1);
      step(1'b0, stream[0], 1'b1, 1'b1);
      step(1'b0, stream[1], 1'b1, 1'b0);
      drain(2, 1);
      run_capture(1);
      drain(6, 1);

      // Start pulses in WAIT and in DONE with data pending are ignored
      for (int i = 0; i < NW; i++) stream[i] = DW'($urandom);
      step(1'b1, DW'($urandom), 1'b0, 1'b1);
      repeat (5) step(1'b0, DW'($urandom), 1'b0, 1'b1);
      step(1'b1, DW'($urandom), 1'b0, 1'b1);
      repeat (WC - 6) step(1'b0, DW'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < NW; i++) step(1'b0, stream[i], 1'b0, 1'b1);
      step(1'b1, DW'($urandom), 1'b0, 1'b1);
      drain(3, 0);
      drain(4, 1);
      run_capture(1);
      drain(6, 1);

      // Out-of-order stream, then a non-decreasing stream with a repeat
      stream[0] = 8'h01; stream[1] = 8'h05; stream[2] = 8'h03; stream[3] = 8'h07;
      run_capture(1);
      drain(6, 1);
      stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h02; stream[3] = 8'h09;
      run_capture(1);
      drain(6, 1);

      // Randomized traffic: starts, stalls, occasional resets
      repeat (1500) step(logic'($urandom_range(0, 9) == 0), DW'($urandom),
                         logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 199) != 0));
      drain(12, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pe_result_drain.md
# pe_result_drain

Reader at the output end of a Nanci PE: after a sort/compute run it samples the PE's `o_PE` word stream at the fixed cycle window where results appear. Captured words are buffered in a small FIFO and handed to a downstream consumer (host bridge or testbench scoreboard) over a valid/ready handshake. Instantiated once per result-producing PE, beside the PE in the mesh wrapper.

## Interface
- `DATA_WIDTH`, 8, width of `o_PE` / result words
- `N`, 4, number of result words captured per run
- `WAIT_CYCLES`, 11, cycles from accepted `i_start` to first capture (SORT_CYCLES + COMPUTE_CYCLES of the attached PE)
- `FIFO_ADDR_WIDTH`, 3, FIFO depth = 2^FIFO_ADDR_WIDTH

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `i_start`  in  1  one-cycle pulse; starts a run, aligned with PE reset release
- `i_PE`  in  DATA_WIDTH  connected to PE `o_PE`
- `o_data`  out  DATA_WIDTH  FIFO head word
- `o_valid`  out  1  `o_data` valid
- `i_ready`  in  1  consumer accepts `o_data` when `o_valid && i_ready`
- `o_busy`  out  1  high in WAIT or CAPTURE
- `o_done`  out  1  high in DONE
- `o_overflow`  out  1  sticky: a captured word was dropped because the FIFO was full

## Operation
- Reset (`rst`==0 at a clock edge): state IDLE, counters 0, FIFO emptied, all outputs 0. Reset takes effect in any state, including mid-capture; in-flight data is discarded.
- States: IDLE, WAIT, CAPTURE, DONE.
- IDLE: `i_start`=1 -> WAIT with wait counter = 0.
- WAIT: counter increments each cycle; when counter == WAIT_CYCLES-1 -> CAPTURE, capture counter = 0. WAIT_CYCLES=0 goes from IDLE directly to CAPTURE.
- CAPTURE: each cycle push `i_PE` into the FIFO, increment capture counter; after the N-th push -> DONE. If the FIFO is full and no pop occurs that cycle, drop the word and set `o_overflow`. The counter still advances.
- DONE: remains until the FIFO is empty and `i_start`=1 -> WAIT. This starts a new run and clears `o_overflow`. `i_start` is ignored in WAIT, CAPTURE, and in DONE while the FIFO is non-empty.
- FIFO: push and pop in the same cycle is allowed, including when full; occupancy is unchanged. Pointers wrap modulo 2^FIFO_ADDR_WIDTH. Occupancy counter is FIFO_ADDR_WIDTH+1 bits.
- Drain continues in every state except reset. The consumer may stall indefinitely.

## Timing
- `i_start` sampled at edge t. Captures occur at edges t+WAIT_CYCLES+1 … t+WAIT_CYCLES+N (the `i_PE` value present before each edge).
- `o_valid` rises 1 cycle after the first push (registered head). `o_data` is stable while `o_valid && !i_ready`.
- `o_done` rises the cycle after the N-th capture edge. `o_busy` is high from t+1 through the N-th capture edge.
- `o_overflow` rises the cycle after the dropping edge.

## Configuration
- `PE_DRAIN_SORTED_CHECK_EN` defined:
  - adds output `o_unsorted` (1 bit, reset 0).
  - Each popped word is compared unsigned against the previous popped word of the same run.
  - If any popped word is less than its predecessor, `o_unsorted` sets sticky. It clears on a new run or on reset.
  - The first pop of a run is not compared.
- Undefined: no port, no comparator, no previous-word register.

## Structure
- Shared package `nanci_pkg`:
  - drain state encoding (IDLE=0, WAIT=1, CAPTURE=2, DONE=3);
  - helper function for counter widths ($clog2-based, minimum 1).
- One sub-module, `drain_fifo`:
  - parameterised sync FIFO;
  - push/pop/full/empty/count ports;
  - registered output.
- Instantiated once by `pe_result_drain`.

## Test plan
- Reset, then `i_start` at edge 3 with `i_PE` = 0x10,0x11,0x12,0x13 on the 4 capture edges, `i_ready`=1 -> `o_data` 0x10..0x13 in order; `o_done`=1; `o_overflow`=0.
- `i_ready`=0 throughout, FIFO_ADDR_WIDTH=1, N=4 -> 2 words held; `o_overflow`=1 the cycle after the 3rd capture edge; releasing ready yields the first 2 words only.
- `rst`=0 for one cycle during the 2nd capture -> all outputs 0 next cycle; a subsequent `i_start` runs a clean 4-word capture.
- `i_start` pulsed during WAIT and during DONE with a non-empty FIFO -> ignored, no counter restart; after the FIFO empties in DONE, `i_start` begins a new run.
- `PE_DRAIN_SORTED_CHECK_EN` defined, stream 0x01,0x05,0x03,0x07 -> `o_unsorted`=1 after the 3rd pop; stream 0x01,0x02,0x02,0x09 -> stays 0.
